// File: rtl/alu_pkg.sv
// Shared ALU types: operation select, operand bundle and status flags, plus
// the sequencer's state encoding, captured-response record and latency bound.
package alu_pkg;

  // Operation select driven to the ALU.
  typedef enum logic [1:0] {
    add      = 2'd0,
    subtract = 2'd1,
    bitw_or  = 2'd2,
    bitw_and = 2'd3
  } control_e;

  // ALU flags; sign is 1 when the result is non-negative.
  typedef struct packed {
    logic sign;
    logic overflow;
    logic zero;
  } status_t;

  // Operand pair presented to the ALU.
  typedef struct packed {
    logic signed [31:0] a;
    logic signed [31:0] b;
  } in_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // Result and flags captured from the ALU.
  typedef struct packed {
    logic signed [31:0] result;
    status_t            status;
  } rsp_t;

  // Largest supported ALU latency and the counter width needed to hold it.
  localparam int ALU_LAT_MAX = 7;
  localparam int CNT_W       = $clog2(ALU_LAT_MAX + 1);

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response channels between the issue logic (master) and the
// ALU operation sequencer (slave).
//
// Handshake rule for both channels: a transfer happens at a rising clock
// edge where valid and ready are both high; the sender keeps valid and its
// payload unchanged until that edge, and valid never depends on ready.
interface alu_op_sequencer_if;
  import alu_pkg::*;

  // Request channel: issue logic -> sequencer.
  logic               req_valid;
  logic               req_ready;
  control_e           req_ctrl;
  logic signed [31:0] req_a;
  logic signed [31:0] req_b;

  // Response channel: sequencer -> issue logic.
  logic               rsp_valid;
  logic               rsp_ready;
  logic signed [31:0] rsp_result;
  status_t            rsp_status;

  modport master (
    output req_valid, req_ctrl, req_a, req_b,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_status,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b,
    output req_ready,
    output rsp_valid, rsp_result, rsp_status,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU operand/status interface. Takes one operation
// request, holds its operands on the ALU for a fixed latency, captures the
// ALU result and flags, and returns them on the response channel. One
// operation is in flight at a time.
//
// Optional feature: define ALU_SEQ_STICKY_OVF_EN to add a sticky overflow
// flag (output sticky_ovf) with a synchronous clear input (sticky_clr).
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,   // edges from operands stable to ALU result valid, 0..ALU_LAT_MAX
  parameter int OPS_W   = 16   // width of the completed-operation counter
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   seq,
  output in_t                 alu_in,
  output control_e            alu_ctrl,
  input  logic signed [31:0]  alu_result,
  input  status_t             alu_status,
  output logic                busy,
  output logic [OPS_W-1:0]    ops_done,
  output seq_state_e          dbg_state
`ifdef ALU_SEQ_STICKY_OVF_EN
  ,
  input  logic                sticky_clr,
  output logic                sticky_ovf
`endif
);

  // Value loaded into the latency counter on accept; the capture happens
  // on the edge where the counter is already zero, giving ALU_LAT+1 edges
  // from accept to capture.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             rsp_valid_q;
  rsp_t             rsp_q;
  logic             capture;

  // The edge on which the ALU output is sampled into the response record.
  assign capture = (state == WAIT) && (cnt == '0);

  // Request channel is open only in IDLE and never while reset is asserted.
  assign seq.req_ready  = (state == IDLE) && !rst;
  assign seq.rsp_valid  = rsp_valid_q;
  assign seq.rsp_result = rsp_q.result;
  assign seq.rsp_status = rsp_q.status;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

  // Control FSM: accept, wait out the ALU latency, capture, hand back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_in      <= '0;
      alu_ctrl    <= add;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      ops_done    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high here, so req_valid alone completes the handshake.
          if (seq.req_valid) begin
            alu_in.a <= seq.req_a;
            alu_in.b <= seq.req_b;
            alu_ctrl <= seq.req_ctrl;
            cnt      <= LAT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Operands stay put on the ALU until the capture edge.
          if (capture) begin
            rsp_q.result <= alu_result;
            rsp_q.status <= alu_status;
            rsp_valid_q  <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // Response and ALU operands are frozen until the requester takes it.
          if (seq.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ops_done    <= ops_done + 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OVF_EN
  // Sticky overflow: a capture with overflow sets it even when a clear
  // arrives on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
    end else if (capture && alu_status.overflow) begin
      sticky_ovf <= 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a directed instance at ALU_LAT=1 plus a
// latency sweep over ALU_LAT in {0,3,7}. Each instance is connected to a
// behavioural ALU that delays its result by ALU_LAT edges. A scoreboard
// queue per instance holds expected responses; monitors compare on every
// response handshake and check accept-to-valid latency.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int W       = 35;   // {result, sign, overflow, zero}
  localparam int N_SWEEP = 100;
  localparam int LATS [3] = '{0, 3, 7};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit sweep_go   = 1'b0;
  int sweep_done = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    bad++;
    $display("FAIL %s: got=timeout expected=event (t=%0t)", name, $time);
  endtask

  // Behavioural ALU: sign=1 for non-negative results, signed overflow on add/sub.
  function automatic logic [W-1:0] alu_calc(control_e c, logic signed [31:0] a,
                                            logic signed [31:0] b);
    logic [31:0] r;
    logic        ovf;
    r   = '0;
    ovf = 1'b0;
    case (c)
      add:      begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      subtract: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      bitw_or:  r = a | b;
      default:  r = a & b;
    endcase
    return {r, ~r[31], ovf, (r == 32'd0)};
  endfunction

  // ---------------- directed instance (ALU_LAT = 1) ----------------
  alu_op_sequencer_if ifc ();
  in_t                alu_in;
  control_e           alu_ctrl;
  logic signed [31:0] alu_result;
  status_t            alu_status;
  logic               busy;
  logic [15:0]        ops_done;
  seq_state_e         dbg_state;
`ifdef ALU_SEQ_STICKY_OVF_EN
  logic               sticky_clr;
  logic               sticky_ovf;
`endif

  alu_op_sequencer #(.ALU_LAT(1), .OPS_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .seq        (ifc.slave),
    .alu_in     (alu_in),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .busy       (busy),
    .ops_done   (ops_done),
    .dbg_state  (dbg_state)
`ifdef ALU_SEQ_STICKY_OVF_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf)
`endif
  );

  logic [W-1:0] d_pipe;
  always @(posedge clk) d_pipe <= alu_calc(alu_ctrl, alu_in.a, alu_in.b);
  assign {alu_result, alu_status} = d_pipe;

  // Scoreboard for the directed instance.
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic         d_prev_v = 1'b0;
  int           ops_exp  = 0;

  always @(negedge clk) begin
    if (ifc.rsp_valid === 1'b1 && d_prev_v !== 1'b1) begin
      if (acc_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL d_unexpected_rsp: got=rsp_valid expected=no response (t=%0t)", $time);
      end else begin
        check("d_latency", 64'(cyc - acc_q.pop_front()), 64'd2);
      end
    end
    if (ifc.rsp_valid === 1'b1 && ifc.rsp_ready === 1'b1) begin
      if (exp_q.size() != 0)
        check("d_rsp", {ifc.rsp_result, ifc.rsp_status}, exp_q.pop_front());
    end
    d_prev_v <= ifc.rsp_valid;
  end

  // Driver: present a request, wait for acceptance, drop valid after the accept edge.
  task automatic issue(control_e c, logic [31:0] a, logic [31:0] b,
                       logic [W-1:0] exp, bit track);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    ifc.req_valid = 1'b1;
    ifc.req_ctrl  = c;
    ifc.req_a     = a;
    ifc.req_b     = b;
    @(negedge clk);
    while (ifc.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (ifc.req_ready !== 1'b1) begin
      fail_now("d_accept");
    end else if (track) begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((ifc.rsp_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) fail_now("d_idle");
  endtask

  task automatic finish_op(string tag);
    wait_idle();
    ops_exp++;
    check({tag, "_ops_done"}, 64'(ops_done), 64'(ops_exp));
  endtask

  task automatic wait_rsp_valid();
    int guard;
    guard = 0;
    @(negedge clk);
    while (ifc.rsp_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (ifc.rsp_valid !== 1'b1) fail_now("d_rsp_valid");
  endtask

  // ---------------- latency sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int LAT = LATS[g];
    localparam int TAP = (LAT == 0) ? 0 : LAT - 1;

    alu_op_sequencer_if s_ifc ();
    in_t                s_in;
    control_e           s_ctrl;
    logic signed [31:0] s_result;
    status_t            s_status;
    logic               s_busy;
    logic [15:0]        s_ops;
    seq_state_e         s_state;
`ifdef ALU_SEQ_STICKY_OVF_EN
    logic               s_sticky;
`endif

    alu_op_sequencer #(.ALU_LAT(LAT), .OPS_W(16)) u_sw (
      .clk        (clk),
      .rst        (rst),
      .seq        (s_ifc.slave),
      .alu_in     (s_in),
      .alu_ctrl   (s_ctrl),
      .alu_result (s_result),
      .alu_status (s_status),
      .busy       (s_busy),
      .ops_done   (s_ops),
      .dbg_state  (s_state)
`ifdef ALU_SEQ_STICKY_OVF_EN
      ,
      .sticky_clr (1'b0),
      .sticky_ovf (s_sticky)
`endif
    );

    logic [W-1:0] now_v;
    logic [W-1:0] pipe [0:7];
    assign now_v = alu_calc(s_ctrl, s_in.a, s_in.b);
    always @(posedge clk) begin
      pipe[0] <= now_v;
      for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
    end
    assign {s_result, s_status} = (LAT == 0) ? now_v : pipe[TAP];

    logic [W-1:0] s_exp_q[$];
    int           s_acc_q[$];
    logic         s_prev_v = 1'b0;

    always @(negedge clk) begin
      if (s_ifc.rsp_valid === 1'b1 && s_prev_v !== 1'b1) begin
        if (s_acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL s%0d_unexpected_rsp: got=rsp_valid expected=no response", LAT);
        end else begin
          check($sformatf("s%0d_latency", LAT), 64'(cyc - s_acc_q.pop_front()), 64'(LAT + 1));
          check($sformatf("s%0d_state", LAT), 64'(s_state), 64'(RESP));
          check($sformatf("s%0d_busy", LAT), 64'(s_busy), 64'd1);
        end
      end
      if (s_ifc.rsp_valid === 1'b1 && s_ifc.rsp_ready === 1'b1) begin
        if (s_exp_q.size() != 0)
          check($sformatf("s%0d_rsp", LAT), {s_ifc.rsp_result, s_ifc.rsp_status},
                s_exp_q.pop_front());
      end
      s_prev_v <= s_ifc.rsp_valid;
    end

    // Random backpressure on the response channel.
    initial begin
      s_ifc.rsp_ready = 1'b1;
      forever begin
        @(posedge clk); #1;
        s_ifc.rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      int guard;
      s_ifc.req_valid = 1'b0;
      s_ifc.req_ctrl  = add;
      s_ifc.req_a     = '0;
      s_ifc.req_b     = '0;
      wait (sweep_go);
      for (int n = 0; n < N_SWEEP; n++) begin
        control_e    c;
        logic [31:0] a;
        logic [31:0] b;
        c = control_e'($urandom_range(0, 3));
        a = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom();
        b = ($urandom_range(0, 4) == 0) ? 32'h0000_0001 : $urandom();
        @(posedge clk); #1;
        s_ifc.req_valid = 1'b1;
        s_ifc.req_ctrl  = c;
        s_ifc.req_a     = a;
        s_ifc.req_b     = b;
        guard = 0;
        @(negedge clk);
        while (s_ifc.req_ready !== 1'b1 && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        if (s_ifc.req_ready !== 1'b1) begin
          fail_now($sformatf("s%0d_accept", LAT));
        end else begin
          s_exp_q.push_back(alu_calc(c, a, b));
          s_acc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        s_ifc.req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      guard = 0;
      while ((s_exp_q.size() != 0 || s_busy !== 1'b0) && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) fail_now($sformatf("s%0d_drain", LAT));
      check($sformatf("s%0d_ops_done", LAT), 64'(s_ops), 64'(N_SWEEP));
      sweep_done++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    rst           = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_ctrl  = add;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    ifc.rsp_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_OVF_EN
    sticky_clr    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_ready", 64'(ifc.req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_req_ready_after", 64'(ifc.req_ready), 64'd1);
    check("rst_rsp", {ifc.rsp_valid, ifc.rsp_result, ifc.rsp_status}, 64'd0);
    check("rst_alu", {alu_in.a, alu_in.b}, 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'(add));
    check("rst_ops_done", 64'(ops_done), 64'd0);
`ifdef ALU_SEQ_STICKY_OVF_EN
    check("rst_sticky", 64'(sticky_ovf), 64'd0);
`endif

    // add 5+7 = 12: positive, no overflow, not zero
    issue(add, 32'd5, 32'd7, {32'd12, 3'b100}, 1'b1);
    check("op1_alu_in", {alu_in.a, alu_in.b}, {32'd5, 32'd7});
    check("op1_busy", 64'(busy), 64'd1);
    finish_op("op1");
    // subtract 3-3 = 0: zero flag
    issue(subtract, 32'd3, 32'd3, {32'd0, 3'b101}, 1'b1);
    finish_op("op2");
    // bitw_and
    issue(bitw_and, 32'hF0F0_0000, 32'h0FF0_0000, {32'h00F0_0000, 3'b100}, 1'b1);
    finish_op("op3");
    // add overflow: 0x7FFFFFFF + 1 = 0x80000000
    issue(add, 32'h7FFF_FFFF, 32'd1, {32'h8000_0000, 3'b010}, 1'b1);
    finish_op("op4");
`ifdef ALU_SEQ_STICKY_OVF_EN
    check("sticky_set", 64'(sticky_ovf), 64'd1);
`endif
    // clean op: sticky holds
    issue(bitw_or, 32'h12, 32'h21, {32'h33, 3'b100}, 1'b1);
    finish_op("op5");
`ifdef ALU_SEQ_STICKY_OVF_EN
    check("sticky_hold", 64'(sticky_ovf), 64'd1);
`endif
    // subtract overflow 0x80000000 - 1; clear asserted exactly on the capture edge
    issue(subtract, 32'h8000_0000, 32'd1, {32'h7FFF_FFFF, 3'b110}, 1'b1);
    @(posedge clk); #1;
`ifdef ALU_SEQ_STICKY_OVF_EN
    sticky_clr = 1'b1;
`endif
    @(posedge clk); #1;
`ifdef ALU_SEQ_STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    finish_op("op6");
`ifdef ALU_SEQ_STICKY_OVF_EN
    check("sticky_set_wins", 64'(sticky_ovf), 64'd1);
    @(posedge clk); #1;
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    check("sticky_clr", 64'(sticky_ovf), 64'd0);
`endif

    // Backpressure: response held 5 cycles with a second request queued.
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b0;
    issue(add, 32'hFFFF_FFFB, 32'd2, {32'hFFFF_FFFD, 3'b000}, 1'b1);
    wait_rsp_valid();
    @(posedge clk); #1;
    ifc.req_valid = 1'b1;
    ifc.req_ctrl  = bitw_or;
    ifc.req_a     = 32'd1;
    ifc.req_b     = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp", {ifc.rsp_valid, ifc.rsp_result, ifc.rsp_status}, {1'b1, 32'hFFFF_FFFD, 3'b000});
      check("bp_alu_in", {alu_in.a, alu_in.b}, {32'hFFFF_FFFB, 32'd2});
      check("bp_alu_ctrl", 64'(alu_ctrl), 64'(add));
      check("bp_req_ready", 64'(ifc.req_ready), 64'd0);
      check("bp_ops_done", 64'(ops_done), 64'(ops_exp));
    end
    @(posedge clk); #1;
    ifc.rsp_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (ifc.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (ifc.req_ready !== 1'b1) begin
      fail_now("bp_release");
    end else begin
      ops_exp++;
      check("bp_ops_after", 64'(ops_done), 64'(ops_exp));
      exp_q.push_back({32'd3, 3'b100});
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    finish_op("bp_queued");

    // Reset during WAIT: op discarded, no response ever appears.
    issue(add, 32'd1, 32'd1, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    check("mid_rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    check("mid_rst_ops_done", 64'(ops_done), 64'd0);
    ops_exp = 0;
    repeat (10) @(negedge clk);
    issue(add, 32'd100, 32'hFFFF_FF9C, {32'd0, 3'b101}, 1'b1);
    finish_op("post_rst");
    check("d_queue_empty", 64'(exp_q.size()), 64'd0);

    // Latency sweep across the other instances.
    sweep_go = 1'b1;
    guard = 0;
    while (sweep_done < 3 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (sweep_done < 3) fail_now("sweep_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
